hmac_tag_checker: RTL
=====================

# hmac_tag_checker

Receive-side companion to the HMAC-SHA256 core. Captures the 256-bit HMAC when the core signals completion, then accepts the expected authentication tag as a byte stream over a valid/ready handshake. Compares every tag byte against the computed HMAC in constant time, with no early exit on mismatch, and reports pass/fail. Sits between the HMAC core's `hmac`/`data_available` outputs and the link or host that delivers the received tag.

## Interface
- `TAG_BYTES`, default 32: number of tag bytes compared. Legal range 16..32. A value below 32 selects a truncated tag, which is the leading bytes of the HMAC.
- `TIMEOUT`, default 1024: stall limit in cycles. Used only when `HMAC_CHK_TIMEOUT_EN` is defined.
- `CLK`  in  1: single clock; all logic on the rising edge.
- `RST`  in  1: asynchronous reset, active-low.
- `hmac_valid`  in  1: connects to the core's `data_available`. A level signal.
- `hmac`  in  256: computed HMAC. Stable while `hmac_valid`=1.
- `tag_byte`  in  8: expected tag byte. Sent MSB-first: byte 0 is compared with `hmac[255:248]`.
- `tag_valid`  in  1: `tag_byte` is valid.
- `tag_ready`  out  1: checker accepts a byte this cycle.
- `done`  out  1: result is valid. Held high.
- `match`  out  1: tag equals the HMAC. Meaningful only while `done`=1.
- `abort`  out  1: one-cycle pulse; the check was abandoned.
- `timeout`  out  1: the check ended on a stall. Meaningful while `done`=1.

## Operation
- States: IDLE, RECV, DONE.
- Reset values: state IDLE; `tag_ready`=0, `done`=0, `match`=0, `abort`=0, `timeout`=0. Byte counter, diff accumulator, HMAC capture register and `hv_q` (the previous `hmac_valid` sample) all reset to 0.
- IDLE:
  - On `hmac_valid`=1 && `hv_q`=0, latch `hmac` into the capture register, clear the counter and the diff accumulator, and go to RECV.
  - Because `hv_q` resets to 0, `hmac_valid` already high when reset is released counts as a rising edge.
- RECV:
  - `tag_ready`=1.
  - A byte transfers when `tag_valid` && `tag_ready`.
  - On each transfer: `diff |= tag_byte ^ capture[255-8*cnt -: 8]`, then `cnt++`. `cnt` is 5 bits.
  - When the transfer with `cnt`==`TAG_BYTES`-1 completes, go to DONE.
  - All `TAG_BYTES` bytes are always consumed. No mismatch shortcut.
- DONE:
  - `done`=1, `match`=(`diff`==0), `tag_ready`=0.
  - Held until `hmac_valid`=0, then go to IDLE. `done`, `match` and `timeout` clear on entry to IDLE.
- Abort: `hmac_valid`=0 while in RECV.
  - Go to IDLE and pulse `abort` for one cycle.
  - `done` stays 0.
  - Abort takes priority over a byte transfer in the same cycle; that byte is not accepted and `tag_ready` drops the next cycle.
- Bytes offered while in IDLE or DONE are not accepted.
- Reset asserted mid-check returns every output to its reset value immediately (asynchronous reset).

## Timing
- Rising edge of `hmac_valid` sampled at clock edge N: `tag_ready`=1 from cycle N+1.
- Throughput: one byte per cycle when `tag_valid` is held high.
- Last byte accepted at edge M: `done` and `match` are valid from cycle M+1.
- With no stalls, `done` asserts `TAG_BYTES`+1 cycles after capture.
- Latency is independent of tag contents (constant-time).
- `abort` is high for exactly the cycle after the edge on which `hmac_valid`=0 was sampled in RECV.

## Configuration
- `HMAC_CHK_TIMEOUT_EN` defined:
  - A stall counter runs in RECV. It resets to 0 on every byte transfer and on entry to RECV.
  - When it reaches `TIMEOUT` consecutive cycles with no transfer, go to DONE with `match`=0 and `timeout`=1.
  - A transfer in the same cycle as the limit wins; the counter clears.
- `HMAC_CHK_TIMEOUT_EN` undefined:
  - No stall counter; RECV waits indefinitely.
  - `timeout` is tied to 0 and `TIMEOUT` is ignored.

## Test plan
- Known-good tag:
  - Stimulus: `hmac`=b0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7 (key 0x0b×20, "Hi There"). `hmac_valid` rises; stream those 32 bytes back-to-back.
  - Response: `done`=1, `match`=1, 33 cycles after capture.
- Last-byte mismatch:
  - Stimulus: same as above, but send final byte f6 instead of f7.
  - Response: `match`=0. `done` asserts on the same cycle as in the known-good case, confirming constant time.
- Truncated tag:
  - Stimulus: `TAG_BYTES`=16; send b0 34 … 2b.
  - Response: `match`=1, `done` 17 cycles after capture. Corrupt byte 0 and `match`=0.
- Abort:
  - Stimulus: drop `hmac_valid` after 10 bytes accepted.
  - Response: one-cycle `abort`, return to IDLE, `tag_ready`=0, `done`=0. A new rising edge of `hmac_valid` starts a fresh check that passes.
- Timeout, with `HMAC_CHK_TIMEOUT_EN` defined and `TIMEOUT`=8:
  - Stimulus: send 5 bytes, then hold `tag_valid`=0.
  - Response: 8 cycles later `done`=1, `match`=0, `timeout`=1.
  - Rerun without the macro: `tag_ready` stays 1 indefinitely.
- Reset mid-check:
  - Stimulus: pull `RST` low after 20 bytes.
  - Response: all outputs 0 asynchronously. After release with `hmac_valid` high, a capture occurs and a full 32-byte stream gives `match`=1.

Source files
------------

// File: rtl/hmac_tag_checker_if.sv
// hmac_tag_checker_if: HMAC capture inputs, tag byte stream and result flags.
// The master drives the HMAC and tag stream; the slave is the checker.
interface hmac_tag_checker_if;
    logic         hmac_valid;
    logic [255:0] hmac;
    logic [7:0]   tag_byte;
    logic         tag_valid;
    logic         tag_ready;
    logic         done;
    logic         match;
    logic         abort;
    logic         timeout;

    modport master (
        output hmac_valid, hmac, tag_byte, tag_valid,
        input  tag_ready, done, match, abort, timeout
    );

    modport slave (
        input  hmac_valid, hmac, tag_byte, tag_valid,
        output tag_ready, done, match, abort, timeout
    );
endinterface

// File: rtl/hmac_tag_checker.sv
// hmac_tag_checker: constant-time compare of a streamed tag against a captured HMAC.
// Optional stall timeout is enabled by defining HMAC_CHK_TIMEOUT_EN.
module hmac_tag_checker #(
    parameter int TAG_BYTES = 32,
    parameter int TIMEOUT   = 1024
) (
    input logic               CLK,
    input logic               RST,
    hmac_tag_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

    localparam logic [4:0] LAST = 5'(TAG_BYTES - 1);

    state_e       state_q;
    logic [255:0] cap_q;
    logic [4:0]   cnt_q;
    logic [7:0]   diff_q;
    logic         hv_q;
    logic         tag_ready_q;
    logic         done_q;
    logic         match_q;
    logic         abort_q;

`ifdef HMAC_CHK_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT - 1);
    logic [SW-1:0] stall_q;
    logic          timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    logic       xfer;
    logic       last;
    logic [7:0] diff_d;

    // The capture register shifts left on every transfer, so the byte
    // under comparison always sits in the top lane.
    assign xfer   = bus.tag_valid && tag_ready_q;
    assign last   = (cnt_q == LAST);
    assign diff_d = diff_q | (bus.tag_byte ^ cap_q[255:248]);

    // Check sequencer: capture, accumulate differences, report.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cap_q       <= '0;
            cnt_q       <= '0;
            diff_q      <= '0;
            hv_q        <= 1'b0;
            tag_ready_q <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            abort_q     <= 1'b0;
`ifdef HMAC_CHK_TIMEOUT_EN
            stall_q     <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            hv_q    <= bus.hmac_valid;
            abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.hmac_valid && !hv_q) begin
                        cap_q       <= bus.hmac;
                        cnt_q       <= '0;
                        diff_q      <= '0;
                        tag_ready_q <= 1'b1;
                        state_q     <= RECV;
`ifdef HMAC_CHK_TIMEOUT_EN
                        stall_q     <= '0;
`endif
                    end
                end
                RECV: begin
                    if (!bus.hmac_valid) begin
                        state_q     <= IDLE;
                        tag_ready_q <= 1'b0;
                        abort_q     <= 1'b1;
                    end else if (xfer) begin
                        diff_q <= diff_d;
                        cap_q  <= {cap_q[247:0], 8'h00};
                        cnt_q  <= cnt_q + 5'd1;
`ifdef HMAC_CHK_TIMEOUT_EN
                        stall_q <= '0;
`endif
                        if (last) begin
                            state_q     <= DONE;
                            tag_ready_q <= 1'b0;
                            done_q      <= 1'b1;
                            match_q     <= (diff_d == 8'h00);
                        end
                    end
`ifdef HMAC_CHK_TIMEOUT_EN
                    else if (stall_q == STALL_LIM) begin
                        state_q     <= DONE;
                        tag_ready_q <= 1'b0;
                        done_q      <= 1'b1;
                        match_q     <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        stall_q <= stall_q + SW'(1);
                    end
`endif
                end
                DONE: begin
                    if (!bus.hmac_valid) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        match_q <= 1'b0;
`ifdef HMAC_CHK_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tag_ready = tag_ready_q;
    assign bus.done      = done_q;
    assign bus.match     = match_q;
    assign bus.abort     = abort_q;
`ifdef HMAC_CHK_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule
